pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter controller for the multicycle MIPS core.
- Owns the PC register and sequences instruction fetch from instruction memory through a req/ack handshake.
- Presents each fetched instruction to decode through a valid/ready handshake.
- Selects the next PC from PC+4, branch, J/JAL jump-target formation, and JR.
- Also provides the retired-instruction counter and fetch-timeout detection.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset (word aligned).
- TIMEOUT, 255, maximum cycles in FETCH without imem_ack before fetch error (1..65535).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instruction held for decode
- instr  out  32  held instruction
- instr_pc  out  32  address of held instruction
- dec_ready  in  1  decode accepts held instruction
- br_take  in  1  conditional branch taken
- br_off  in  16  branch offset (instruction words)
- jump  in  1  J/JAL redirect
- jump_index  in  26  instr_index field
- jr  in  1  JR/JALR redirect
- jr_target  in  32  register target
- halt  in  1  stop after this instruction
- halted  out  1  sequencer in HALTED
- err  out  2  sticky error: bit0 misaligned JR target, bit1 fetch timeout
- retired  out  32  accepted-instruction count

Behaviour:
- Reset values: pc=RESET_PC; state=BOOT; imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, err=0, retired=0; timeout counter=0; pending redirect cleared.
- Reset wins over every other input in the same cycle.
- States:
  - BOOT: -> FETCH unconditionally after one cycle.
  - FETCH: imem_req=1, imem_addr=pc, timeout counter increments each cycle.
    - On imem_ack: instr<=imem_rdata, instr_pc<=pc, counter cleared, -> HOLD.
    - If counter reaches TIMEOUT with no ack: err[1]<=1, -> HALTED.
  - HOLD: instr_valid=1; instr, instr_pc, imem_req=0 held stable until dec_ready.
    - Accept = instr_valid & dec_ready. On accept: retired+=1 (wraps at 2^32), pc<=next_pc.
    - On accept, go to HALTED if halt, else FETCH.
  - HALTED: halted=1, all requests 0. Exit only via rst.
- Redirect inputs are sampled only on accept; ignored otherwise.
- next_pc, with p4 = instr_pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000). Priority when several are asserted: jr > jump > br_take > p4.
  - jr: jr_target. If jr_target[1:0]!=0, err[0]<=1 and -> HALTED; pc unchanged.
  - jump: {p4[31:28], jump_index, 2'b00}. Full 32-bit result; the upper nibble comes from p4, not instr_pc.
  - br_take: p4 + (sign-extended br_off << 2), 32-bit wrap.
- Minimum throughput: 2 cycles per instruction (ack in first FETCH cycle, dec_ready high in first HOLD cycle).
- imem_ack outside FETCH is ignored.
- rst during FETCH: imem_req drops the next cycle. An ack arriving in the BOOT cycle is discarded.

Optional Feature:
- Macro: PC_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot.
  - On an accepted redirect, the computed target is stored as pending and pc<=p4; the slot instruction is fetched next.
  - When the slot instruction is accepted, pc<=pending target and pending clears. Any redirect inputs on the slot are ignored.
  - halt on the slot instruction still halts; pending is discarded.
  - A misaligned JR target flags err[0] when the JR is accepted; HALTED is entered after the slot is accepted.
- Undefined: redirect takes effect immediately as described above; no pending register is generated.

Test Plan:
- Reset, then ack every FETCH with rdata=i, dec_ready=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008; instr_valid pulses every 2nd cycle; retired=3 after third accept.
- instr_pc=0x0FFF_FFFC, jump=1, jump_index=26'h0000040 -> next imem_addr=0x1000_0100 (upper nibble from p4).
- instr_pc=0x3010, br_take=1, br_off=16'hFFFC -> next imem_addr=0x3004; jr=1 with jr_target=0x4000 in the same accept -> 0x4000 (jr priority).
- dec_ready low 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, retired unchanged; jr_target=0x3002 on accept -> err=2'b01, halted=1.
- Withhold imem_ack for TIMEOUT cycles (TIMEOUT=8) -> err[1]=1, halted=1. Then pulse rst mid-FETCH -> all outputs at reset values, imem_addr=RESET_PC one cycle later.
- With PC_DELAY_SLOT_EN: jump at 0x3000 to 0x3100 -> fetch order 0x3004, then 0x3100. A br_take on the slot is ignored.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multicycle MIPS core: fetches over a
// req/ack port, holds each word for decode, and selects the next PC.
// Optional macro PC_DELAY_SLOT_EN enables the MIPS branch delay slot.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        dec_ready,
  input  logic        br_take,
  input  logic [15:0] br_off,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic        halted,
  output logic [1:0]  err,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_HALTED
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_nxt, instr_pc_nxt, retired_nxt;
  logic [1:0]  err_nxt;
  logic [15:0] tmo_cnt, tmo_nxt;

  logic        accept;
  logic        redirect;
  logic        jr_bad;
  logic [31:0] p4, br_tgt, j_tgt, redir_tgt;

`ifdef PC_DELAY_SLOT_EN
  logic        pend_valid, pend_valid_nxt;
  logic        pend_bad, pend_bad_nxt;
  logic [31:0] pend_target, pend_target_nxt;
`endif

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign halted      = (state == S_HALTED);
  assign accept      = instr_valid & dec_ready;

  // Target formation; the jump's upper nibble comes from the incremented PC.
  assign p4       = instr_pc + 32'd4;
  assign br_tgt   = p4 + {{14{br_off[15]}}, br_off, 2'b00};
  assign j_tgt    = {p4[31:28], jump_index, 2'b00};
  assign redirect = jr | jump | br_take;
  assign jr_bad   = jr & (jr_target[1:0] != 2'b00);

  always_comb begin
    redir_tgt = p4;
    if (jr)           redir_tgt = jr_target;
    else if (jump)    redir_tgt = j_tgt;
    else if (br_take) redir_tgt = br_tgt;
  end

  // NOTE: every signal assigned below gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    err_nxt      = err;
    retired_nxt  = retired;
    tmo_nxt      = tmo_cnt;
`ifdef PC_DELAY_SLOT_EN
    pend_valid_nxt  = pend_valid;
    pend_bad_nxt    = pend_bad;
    pend_target_nxt = pend_target;
`endif
    case (state)
      S_BOOT: begin
        tmo_nxt   = '0;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_nxt    = imem_rdata;
          instr_pc_nxt = pc;
          tmo_nxt      = '0;
          state_nxt    = S_HOLD;
        end else if (tmo_cnt == TMO_LAST) begin
          err_nxt[1] = 1'b1;
          tmo_nxt    = '0;
          state_nxt  = S_HALTED;
        end else begin
          tmo_nxt = tmo_cnt + 16'd1;
        end
      end
      S_HOLD: begin
        if (accept) begin
          retired_nxt = retired + 32'd1;
`ifdef PC_DELAY_SLOT_EN
          if (pend_valid) begin
            // Slot instruction: its own redirect inputs are ignored.
            if (!pend_bad) pc_nxt = pend_target;
            pend_valid_nxt = 1'b0;
            pend_bad_nxt   = 1'b0;
            state_nxt      = (halt || pend_bad) ? S_HALTED : S_FETCH;
          end else begin
            pc_nxt = p4;
            if (redirect) begin
              pend_valid_nxt  = 1'b1;
              pend_target_nxt = redir_tgt;
              pend_bad_nxt    = jr_bad;
              if (jr_bad) err_nxt[0] = 1'b1;
            end
            state_nxt = halt ? S_HALTED : S_FETCH;
          end
`else
          if (jr_bad) begin
            err_nxt[0] = 1'b1;
            state_nxt  = S_HALTED;
          end else begin
            pc_nxt    = redirect ? redir_tgt : p4;
            state_nxt = halt ? S_HALTED : S_FETCH;
          end
`endif
        end
      end
      S_HALTED: ;
      default: state_nxt = S_HALTED;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
      err      <= '0;
      retired  <= '0;
      tmo_cnt  <= '0;
`ifdef PC_DELAY_SLOT_EN
      pend_valid  <= 1'b0;
      pend_bad    <= 1'b0;
      pend_target <= '0;
`endif
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr    <= instr_nxt;
      instr_pc <= instr_pc_nxt;
      err      <= err_nxt;
      retired  <= retired_nxt;
      tmo_cnt  <= tmo_nxt;
`ifdef PC_DELAY_SLOT_EN
      pend_valid  <= pend_valid_nxt;
      pend_bad    <= pend_bad_nxt;
      pend_target <= pend_target_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected fetch addresses are queued as
// stimulus is driven and popped when the sequencer raises imem_req.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready;
  logic        br_take;
  logic [15:0] br_off;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        halt;
  logic        halted;
  logic [1:0]  err;
  logic [31:0] retired;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_ret;
  logic [31:0] exp_word;

  pc_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .dec_ready(dec_ready),
    .br_take(br_take), .br_off(br_off),
    .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target),
    .halt(halt), .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_redirect();
    br_take = 1'b0; br_off = '0; jump = 1'b0; jump_index = '0;
    jr = 1'b0; jr_target = '0; halt = 1'b0;
  endtask

  task automatic check_reset();
    check("rst_req",     {31'b0, imem_req},    32'd0);
    check("rst_addr",    imem_addr,            RESET_PC);
    check("rst_valid",   {31'b0, instr_valid}, 32'd0);
    check("rst_instr",   instr,                32'd0);
    check("rst_ipc",     instr_pc,             32'd0);
    check("rst_halted",  {31'b0, halted},      32'd0);
    check("rst_err",     {30'b0, err},         32'd0);
    check("rst_retired", retired,              32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the ack was taken.
  task automatic fetch_at(input logic [31:0] addr);
    int n = 0;
    exp_q.push_back(addr);
    while (imem_req !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_q.pop_front());
    imem_ack   = 1'b1;
    imem_rdata = addr ^ KEY;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  // Redirect inputs are set by the caller before this is invoked.
  task automatic accept_at(input logic [31:0] addr);
    check("hold_valid", {31'b0, instr_valid}, 32'd1);
    check("hold_instr", instr, addr ^ KEY);
    check("hold_ipc", instr_pc, addr);
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    clear_redirect();
    exp_ret = exp_ret + 32'd1;
    check("retired", retired, exp_ret);
  endtask

  // Fetch the landing target of a redirect; with a delay slot the slot
  // instruction at p4 comes first and a branch request on it must be ignored.
  task automatic land(input logic [31:0] target, input logic [31:0] p4);
`ifdef PC_DELAY_SLOT_EN
    fetch_at(p4);
    br_take = 1'b1;
    br_off  = 16'h0010;
    accept_at(p4);
`endif
    fetch_at(target);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
    clear_redirect();
    exp_ret = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back fetches at full throughput.
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(RESET_PC + 32'(4 * i));
      check("seq_req", {31'b0, imem_req}, 32'd1);
      check("seq_valid_lo", {31'b0, instr_valid}, 32'd0);
      check("seq_addr", imem_addr, exp_q.pop_front());
      imem_ack   = 1'b1;
      imem_rdata = 32'h100 + 32'(i);
      @(negedge clk);
      check("seq_valid_hi", {31'b0, instr_valid}, 32'd1);
      check("seq_req_lo", {31'b0, imem_req}, 32'd0);
      check("seq_instr", instr, 32'h100 + 32'(i));
      check("seq_ipc", instr_pc, RESET_PC + 32'(4 * i));
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    imem_ack = 1'b0; dec_ready = 1'b0;
    exp_ret = 32'd3;
    check("seq_retired", retired, exp_ret);

    // JR to 0x0FFF_FFFC, then J whose upper nibble comes from p4.
    fetch_at(32'h0000_300C);
    jr = 1'b1; jr_target = 32'h0FFF_FFFC;
    accept_at(32'h0000_300C);
    land(32'h0FFF_FFFC, 32'h0000_3010);
    jump = 1'b1; jump_index = 26'h000_0040;
    accept_at(32'h0FFF_FFFC);
    land(32'h1000_0100, 32'h1000_0000);

    // Negative branch, positive branch, then jr beating a branch.
    jr = 1'b1; jr_target = 32'h0000_3010;
    accept_at(32'h1000_0100);
    land(32'h0000_3010, 32'h1000_0104);
    br_take = 1'b1; br_off = 16'hFFFC;
    accept_at(32'h0000_3010);
    land(32'h0000_3004, 32'h0000_3014);
    br_take = 1'b1; br_off = 16'h0002;
    accept_at(32'h0000_3004);
    land(32'h0000_3010, 32'h0000_3008);
    br_take = 1'b1; br_off = 16'hFFFC; jr = 1'b1; jr_target = 32'h0000_4000;
    accept_at(32'h0000_3010);
    land(32'h0000_4000, 32'h0000_3014);

    // Decode stall: held state stays put while ack toggles outside FETCH.
    for (int i = 0; i < 5; i++) begin
      imem_ack = i[0]; imem_rdata = 32'h1234_5678;
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_instr", instr, 32'h0000_4000 ^ KEY);
      check("stall_ipc", instr_pc, 32'h0000_4000);
      check("stall_retired", retired, exp_ret);
      @(negedge clk);
    end
    imem_ack = 1'b0; imem_rdata = '0;

    // Misaligned JR target.
    jr = 1'b1; jr_target = 32'h0000_3002;
    accept_at(32'h0000_4000);
    check("jr_bad_err", {30'b0, err}, 32'd1);
`ifdef PC_DELAY_SLOT_EN
    check("jr_bad_not_yet", {31'b0, halted}, 32'd0);
    fetch_at(32'h0000_4004);
    accept_at(32'h0000_4004);
`else
    check("jr_bad_pc", imem_addr, 32'h0000_4000);
`endif
    check("jr_bad_halted", {31'b0, halted}, 32'd1);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    check("halted_stays", {31'b0, halted}, 32'd1);
    check("halted_req", {31'b0, imem_req}, 32'd0);
    check("halted_retired", retired, exp_ret);

    // Fetch timeout: eight FETCH cycles without ack.
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0; exp_ret = '0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check("tmo_req", {31'b0, imem_req}, 32'd1);
      check("tmo_not_halted", {31'b0, halted}, 32'd0);
      @(negedge clk);
    end
    check("tmo_halted", {31'b0, halted}, 32'd1);
    check("tmo_err", {30'b0, err}, 32'd2);
    check("tmo_req_lo", {31'b0, imem_req}, 32'd0);

    // Jump 0x3000 -> 0x3100, then reset in the middle of a fetch.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fetch_at(RESET_PC);
    jump = 1'b1; jump_index = 26'h000_0C40;
    accept_at(RESET_PC);
    land(32'h0000_3100, 32'h0000_3004);
    accept_at(32'h0000_3100);
    check("mid_req", {31'b0, imem_req}, 32'd1);
    check("mid_addr", imem_addr, 32'h0000_3104);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_reset();
    rst = 1'b0; exp_ret = '0;
    @(negedge clk);
    imem_ack = 1'b0;
    check("boot_ack_ignored", {31'b0, instr_valid}, 32'd0);
    check("after_rst_addr", imem_addr, RESET_PC);
    fetch_at(RESET_PC);
    accept_at(RESET_PC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
